// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C transaction engine among N requesters,
// sequencing start/finish, guarding each transaction with a timeout and routing status back.
module i2c_txn_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CW          = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [7*N-1:0] req_addr,
  input  logic [N-1:0]   req_rw,
  input  logic [8*N-1:0] req_wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [7:0]     rsp_rdata,
  output logic           rsp_err,
  output logic           eng_start,
  output logic [6:0]     eng_addr,
  output logic           eng_rw,
  output logic [7:0]     eng_wdata,
  output logic           eng_abort,
  input  logic           eng_finish,
  input  logic [7:0]     eng_rdata,
  input  logic           eng_nack,
  output logic           busy,
  output logic [1:0]     state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] PTR_INIT   = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_ACTIVE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t        cur, nxt;
  logic [IW-1:0] ptr, ptr_n, owner, owner_n, winner;
  logic          found;
  logic [CW-1:0] timer, timer_n;
  logic          timeout_hit;

  logic [N-1:0]  gnt_n, done_n;
  logic [7:0]    rdata_n, wdata_n;
  logic [6:0]    addr_n;
  logic          err_n, start_n, rw_n, abort_n;

  assign timeout_hit = (timer == TIMER_LAST);
  assign state       = cur;

  // Rotating priority scan: first set request after the last served requester.
  always_comb begin
    logic [IW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = ptr;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (found) nxt = S_ISSUE;
      S_ISSUE:  nxt = S_ACTIVE;
      S_ACTIVE: if (eng_finish || timeout_hit) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_n   = '0;
    done_n  = '0;
    start_n = 1'b0;
    abort_n = 1'b0;
    rdata_n = rsp_rdata;
    err_n   = rsp_err;
    addr_n  = eng_addr;
    rw_n    = eng_rw;
    wdata_n = eng_wdata;
    owner_n = owner;
    ptr_n   = ptr;
    timer_n = timer;
    case (cur)
      S_IDLE: begin
        if (found) begin
          gnt_n[winner] = 1'b1;
          start_n       = 1'b1;
          addr_n        = req_addr[7*winner +: 7];
          rw_n          = req_rw[winner];
          wdata_n       = req_wdata[8*winner +: 8];
          owner_n       = winner;
        end
      end
      S_ISSUE: timer_n = '0;
      S_ACTIVE: begin
        if (timer != '1) timer_n = timer + 1'b1;
        // A finish arriving on the timeout cycle takes precedence over the abort.
        if (eng_finish) begin
          rdata_n       = eng_rw ? eng_rdata : 8'h00;
          err_n         = eng_nack;
          done_n[owner] = 1'b1;
        end else if (timeout_hit) begin
          abort_n       = 1'b1;
          err_n         = 1'b1;
          rdata_n       = 8'h00;
          done_n[owner] = 1'b1;
        end
      end
      S_DONE:  ptr_n = owner;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_addr  <= '0;
      eng_rw    <= 1'b0;
      eng_wdata <= '0;
      eng_abort <= 1'b0;
      busy      <= 1'b0;
      owner     <= '0;
      ptr       <= PTR_INIT;
      timer     <= '0;
    end else begin
      gnt       <= gnt_n;
      done      <= done_n;
      rsp_rdata <= rdata_n;
      rsp_err   <= err_n;
      eng_start <= start_n;
      eng_addr  <= addr_n;
      eng_rw    <= rw_n;
      eng_wdata <= wdata_n;
      eng_abort <= abort_n;
      busy      <= (nxt != S_IDLE);
      owner     <= owner_n;
      ptr       <= ptr_n;
      timer     <= timer_n;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios plus randomized
// transactions scored against a round-robin reference model.
module tb_i2c_txn_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rsp_rdata;
  logic           rsp_err, eng_start, eng_rw, eng_abort;
  logic [6:0]     eng_addr;
  logic [7:0]     eng_wdata;
  logic           eng_finish;
  logic [7:0]     eng_rdata;
  logic           eng_nack;
  logic           busy;
  logic [1:0]     state;

  i2c_txn_arbiter #(.N(N), .TIMEOUT_CYC(TO), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .eng_start(eng_start), .eng_addr(eng_addr), .eng_rw(eng_rw),
    .eng_wdata(eng_wdata), .eng_abort(eng_abort), .eng_finish(eng_finish),
    .eng_rdata(eng_rdata), .eng_nack(eng_nack), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_pulses = 0;
  int abort_pulses = 0;
  int ptr_m;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    done_pulses  <= done_pulses + ((done != '0) ? 1 : 0);
    abort_pulses <= abort_pulses + (eng_abort ? 1 : 0);
  end

  logic [2*N+29:0] allout;
  assign allout = {gnt, done, rsp_rdata, rsp_err, eng_start, eng_addr, eng_rw,
                   eng_wdata, eng_abort, busy, state};

  // Captured observations at grant and at completion.
  logic [N-1:0] g_vec;
  logic         g_start, g_rw;
  logic [6:0]   g_addr;
  logic [7:0]   g_wdata;
  logic [1:0]   g_state;
  int           g_cyc;
  logic [N-1:0] d_vec;
  logic [7:0]   d_rdata;
  logic         d_err, d_abort;
  logic [6:0]   d_addr;
  logic [1:0]   d_state;
  int           d_cyc;

  // Reference arbitration rule: first set bit scanning p+1, p+2, ... mod N.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[7*i +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[8*i +: 8] = wd;
    req[i]              = 1'b1;
  endtask

  task automatic wait_gnt(input int budget);
    g_vec = '0; g_cyc = -1000; g_start = 1'b0; g_addr = '0; g_rw = 1'b0; g_wdata = '0; g_state = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g_vec = gnt; g_start = eng_start; g_addr = eng_addr; g_rw = eng_rw;
        g_wdata = eng_wdata; g_state = state; g_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic finish_at(input int k, input logic [7:0] rd, input logic nk);
    repeat (k) @(negedge clk);
    eng_finish = 1'b1; eng_rdata = rd; eng_nack = nk;
  endtask

  task automatic wait_done(input int budget);
    d_vec = '0; d_cyc = -1000; d_rdata = 8'hxx; d_err = 1'bx; d_abort = 1'bx; d_addr = '0; d_state = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      eng_finish = 1'b0;
      if (done != '0) begin
        d_vec = done; d_rdata = rsp_rdata; d_err = rsp_err; d_abort = eng_abort;
        d_addr = eng_addr; d_state = state; d_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; eng_finish = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = N - 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (allout !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", allout); end
    reset = 1'b0;
    ptr_m = N - 1;
    @(negedge clk);
    vectors++;
    if (allout !== '0) begin miscompares++; $display("FAIL idle_after_reset: got %h want 0", allout); end
  endtask

  task automatic test_single_write();
    int c;
    set_req(0, 7'h68, 1'b0, 8'h6B);
    c = cyc;
    wait_gnt(5);
    req = '0;
    vectors++;
    if ({g_vec, g_start, g_addr, g_rw, g_wdata, g_state} !== {4'b0001, 1'b1, 7'h68, 1'b0, 8'h6B, 2'b01}) begin
      miscompares++;
      $display("FAIL write_grant: got gnt=%b st=%b a=%h rw=%b wd=%h s=%b want 0001 1 68 0 6b 01",
               g_vec, g_start, g_addr, g_rw, g_wdata, g_state);
    end
    vectors++;
    if (g_cyc - c !== 1) begin miscompares++; $display("FAIL write_gnt_latency: got %0d want 1", g_cyc - c); end
    finish_at(5, 8'hFF, 1'b0);
    wait_done(TO + 8);
    vectors++;
    if ({d_vec, d_rdata, d_err, d_abort, d_addr, d_state} !== {4'b0001, 8'h00, 1'b0, 1'b0, 7'h68, 2'b11}) begin
      miscompares++;
      $display("FAIL write_done: got done=%b rd=%h err=%b ab=%b a=%h s=%b want 0001 00 0 0 68 11",
               d_vec, d_rdata, d_err, d_abort, d_addr, d_state);
    end
    vectors++;
    if (d_cyc - g_cyc !== 6) begin miscompares++; $display("FAIL write_done_latency: got %0d want 6", d_cyc - g_cyc); end
    @(negedge clk);
    vectors++;
    if ({state, busy, done} !== {2'b00, 1'b0, 4'b0000}) begin
      miscompares++; $display("FAIL write_back_idle: got s=%b busy=%b done=%b want 00 0 0000", state, busy, done);
    end
    ptr_m = 0;
  endtask

  task automatic test_read_nack();
    set_req(2, 7'h1E, 1'b1, 8'h00);
    wait_gnt(5);
    req = '0;
    vectors++;
    if ({g_vec, g_addr, g_rw} !== {4'b0100, 7'h1E, 1'b1}) begin
      miscompares++; $display("FAIL read_grant: got gnt=%b a=%h rw=%b want 0100 1e 1", g_vec, g_addr, g_rw);
    end
    finish_at(3, 8'hA5, 1'b1);
    wait_done(TO + 8);
    vectors++;
    if ({d_vec, d_rdata, d_err, d_abort} !== {4'b0100, 8'hA5, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL read_nack_done: got done=%b rd=%h err=%b ab=%b want 0100 a5 1 0",
                              d_vec, d_rdata, d_err, d_abort);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_rdata, rsp_err} !== {8'hA5, 1'b1}) begin
      miscompares++; $display("FAIL rsp_hold: got rd=%h err=%b want a5 1", rsp_rdata, rsp_err);
    end
    ptr_m = 2;
  endtask

  task automatic test_round_robin();
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 7'(7'h10 + i), 1'b0, 8'(8'h80 + i));
    for (int j = 0; j < 8; j++) begin
      wait_gnt(8);
      if (j == 5) req = 4'b1010;
      vectors++;
      if ({g_vec, g_addr} !== {4'(1 << exp_seq[j]), 7'(7'h10 + exp_seq[j])}) begin
        miscompares++; $display("FAIL rr_grant_%0d: got gnt=%b a=%h want %b %h", j, g_vec, g_addr,
                                4'(1 << exp_seq[j]), 7'(7'h10 + exp_seq[j]));
      end
      finish_at(3, 8'h00, 1'b0);
      wait_done(TO + 8);
      vectors++;
      if (d_vec !== 4'(1 << exp_seq[j])) begin
        miscompares++; $display("FAIL rr_done_%0d: got %b want %b", j, d_vec, 4'(1 << exp_seq[j]));
      end
    end
    req = '0;
    @(negedge clk);
    ptr_m = 1;
  endtask

  task automatic test_timeout();
    int a0, dp;
    set_req(3, 7'h55, 1'b1, 8'h00);
    wait_gnt(5);
    req = '0;
    a0 = abort_pulses;
    vectors++;
    if (g_vec !== 4'b1000) begin miscompares++; $display("FAIL to_grant: got %b want 1000", g_vec); end
    wait_done(TO + 8);
    vectors++;
    if ({d_vec, d_rdata, d_err, d_abort} !== {4'b1000, 8'h00, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL to_done: got done=%b rd=%h err=%b ab=%b want 1000 00 1 1",
                              d_vec, d_rdata, d_err, d_abort);
    end
    vectors++;
    if (d_cyc - g_cyc !== TO + 1) begin
      miscompares++; $display("FAIL to_latency: got %0d want %0d", d_cyc - g_cyc, TO + 1);
    end
    @(negedge clk);
    dp = done_pulses;
    @(negedge clk);
    eng_finish = 1'b1; eng_rdata = 8'h77; eng_nack = 1'b0;
    @(negedge clk);
    eng_finish = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({done_pulses - dp, abort_pulses - a0, state, rsp_rdata, rsp_err} !== {32'd0, 32'd1, 2'b00, 8'h00, 1'b1}) begin
      miscompares++; $display("FAIL late_finish: got dones=%0d aborts=%0d s=%b rd=%h err=%b want 0 1 00 00 1",
                              done_pulses - dp, abort_pulses - a0, state, rsp_rdata, rsp_err);
    end
    ptr_m = 3;
    set_req(0, 7'h22, 1'b1, 8'h00);
    wait_gnt(5);
    req = '0;
    a0 = abort_pulses;
    finish_at(TO, 8'h3C, 1'b0);
    wait_done(TO + 8);
    @(negedge clk);
    vectors++;
    if ({d_vec, d_rdata, d_err, d_abort} !== {4'b0001, 8'h3C, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL tie_finish_wins: got done=%b rd=%h err=%b ab=%b want 0001 3c 0 0",
                              d_vec, d_rdata, d_err, d_abort);
    end
    vectors++;
    if ({d_cyc - g_cyc, abort_pulses - a0} !== {32'(TO + 1), 32'd0}) begin
      miscompares++; $display("FAIL tie_timing: got lat=%0d aborts=%0d want %0d 0", d_cyc - g_cyc, abort_pulses - a0, TO + 1);
    end
    ptr_m = 0;
  endtask

  task automatic test_reset_mid();
    int dp, c;
    set_req(1, 7'h40, 1'b0, 8'h99);
    wait_gnt(5);
    req = '0;
    vectors++;
    if (g_vec !== 4'b0010) begin miscompares++; $display("FAIL mid_grant: got %b want 0010", g_vec); end
    repeat (3) @(negedge clk);
    dp = done_pulses;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (allout !== '0) begin miscompares++; $display("FAIL async_reset: got %h want 0", allout); end
    @(negedge clk);
    set_req(0, 7'h0A, 1'b1, 8'h00);
    set_req(1, 7'h0B, 1'b0, 8'h11);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = N - 1;
    c = cyc;
    wait_gnt(5);
    req = '0;
    vectors++;
    if ({g_vec, g_addr, g_cyc - c, done_pulses - dp} !== {4'b0001, 7'h0A, 32'd1, 32'd0}) begin
      miscompares++; $display("FAIL post_reset_grant: got gnt=%b a=%h lat=%0d dones=%0d want 0001 0a 1 0",
                              g_vec, g_addr, g_cyc - c, done_pulses - dp);
    end
    finish_at(2, 8'h5E, 1'b0);
    wait_done(TO + 8);
    vectors++;
    if ({d_vec, d_rdata} !== {4'b0001, 8'h5E}) begin
      miscompares++; $display("FAIL post_reset_done: got %b %h want 0001 5e", d_vec, d_rdata);
    end
    @(negedge clk);
    ptr_m = 0;
  endtask

  task automatic test_busy_request();
    set_req(0, 7'h33, 1'b0, 8'hC3);
    wait_gnt(5);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    set_req(1, 7'h2A, 1'b1, 8'h5A);
    finish_at(2, 8'h00, 1'b0);
    wait_done(TO + 8);
    vectors++;
    if (d_vec !== 4'b0001) begin miscompares++; $display("FAIL busy_first_done: got %b want 0001", d_vec); end
    wait_gnt(6);
    req = '0;
    vectors++;
    if ({g_vec, g_addr, g_rw, g_wdata, g_cyc - d_cyc} !== {4'b0010, 7'h2A, 1'b1, 8'h5A, 32'd2}) begin
      miscompares++; $display("FAIL busy_pending_grant: got gnt=%b a=%h rw=%b wd=%h gap=%0d want 0010 2a 1 5a 2",
                              g_vec, g_addr, g_rw, g_wdata, g_cyc - d_cyc);
    end
    finish_at(1, 8'h9D, 1'b0);
    wait_done(TO + 8);
    vectors++;
    if ({d_vec, d_rdata, d_err} !== {4'b0010, 8'h9D, 1'b0}) begin
      miscompares++; $display("FAIL busy_second_done: got %b %h %b want 0010 9d 0", d_vec, d_rdata, d_err);
    end
    ptr_m = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [6:0]   ea[N];
    logic         erw[N];
    logic [7:0]   ewd[N];
    logic [7:0]   rd, exp_rd;
    logic         nk, exp_err, exp_ab, tmo;
    int           win, k, c, exp_lat;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        ea[i] = 7'($urandom); erw[i] = 1'($urandom); ewd[i] = 8'($urandom);
        if (r[i]) set_req(i, ea[i], erw[i], ewd[i]);
      end
      win = rr_pick(r, ptr_m);
      c = cyc;
      wait_gnt(5);
      req = '0;
      vectors++;
      if ({g_vec, g_addr, g_rw, g_wdata, g_cyc - c} !== {4'(1 << win), ea[win], erw[win], ewd[win], 32'd1}) begin
        miscompares++; $display("FAIL rand_grant_%0d: got gnt=%b a=%h rw=%b wd=%h lat=%0d want %b %h %b %h 1",
                                it, g_vec, g_addr, g_rw, g_wdata, g_cyc - c, 4'(1 << win), ea[win], erw[win], ewd[win]);
      end
      tmo = ($urandom_range(0, 3) == 0);
      if (tmo) begin
        exp_rd = 8'h00; exp_err = 1'b1; exp_ab = 1'b1; exp_lat = TO + 1;
      end else begin
        k = $urandom_range(1, TO);
        rd = 8'($urandom); nk = 1'($urandom);
        finish_at(k, rd, nk);
        exp_rd = erw[win] ? rd : 8'h00; exp_err = nk; exp_ab = 1'b0; exp_lat = k + 1;
      end
      wait_done(TO + 8);
      vectors++;
      if ({d_vec, d_rdata, d_err, d_abort, d_cyc - g_cyc} !== {4'(1 << win), exp_rd, exp_err, exp_ab, 32'(exp_lat)}) begin
        miscompares++; $display("FAIL rand_done_%0d: got done=%b rd=%h err=%b ab=%b lat=%0d want %b %h %b %b %0d",
                                it, d_vec, d_rdata, d_err, d_abort, d_cyc - g_cyc,
                                4'(1 << win), exp_rd, exp_err, exp_ab, exp_lat);
      end
      ptr_m = win;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    eng_finish = 1'b0; eng_rdata = '0; eng_nack = 1'b0; ptr_m = N - 1;
    test_reset();
    test_single_write();
    test_read_nack();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_busy_request();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
